// File: rtl/harness_ctrl_if.sv
// Harness control bus: loader command channel, ctrl bus toward the DUT
// wrapper, DUT stall/read-return signals and the response channel.
interface harness_ctrl_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          cmd_ready;

    logic          ctrl_ready;
    logic          ctrl_write;
    logic [AW-1:0] ctrl_addr;
    logic [DW-1:0] ctrl_data;

    logic          dut_cwait;
    logic          dut_cready;
    logic [DW-1:0] dut_data;
    logic [AW-1:0] dut_addr;

    logic          rsp_valid;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic          rsp_error;
    logic          rsp_timeout;
    logic          busy;

    // Driver side: owns the ctrl bus and the response channel.
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_data,
        output cmd_ready,
        output ctrl_ready, ctrl_write, ctrl_addr, ctrl_data,
        input  dut_cwait, dut_cready, dut_data, dut_addr,
        output rsp_valid, rsp_addr, rsp_data, rsp_error, rsp_timeout, busy
    );

    // Loader/DUT side: offers commands, answers the ctrl bus.
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_data,
        input  cmd_ready,
        input  ctrl_ready, ctrl_write, ctrl_addr, ctrl_data,
        output dut_cwait, dut_cready, dut_data, dut_addr,
        input  rsp_valid, rsp_addr, rsp_data, rsp_error, rsp_timeout, busy
    );
endinterface

// File: rtl/harness_ctrl_driver.sv
// Initiator end of the harness control bus. Commands are queued in a small
// FIFO, issued onto ctrl_*, held while the DUT stalls and retired either
// normally or after TMO consecutive stall cycles.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | nothing on the ctrl bus, waiting for a queued command
// S_ACTIVE| command on the ctrl bus, waiting for dut_cwait low or timeout
module harness_ctrl_driver #(
    parameter int AW    = 16,
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int TMO   = 16
) (
    input logic           clk,
    input logic           reset,
    harness_ctrl_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(TMO);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    logic          fifo_write_q [DEPTH];
    logic [AW-1:0] fifo_addr_q  [DEPTH];
    logic [DW-1:0] fifo_data_q  [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;

    logic          ctrl_ready_q, ctrl_ready_d;
    logic          ctrl_write_q, ctrl_write_d;
    logic [AW-1:0] ctrl_addr_q,  ctrl_addr_d;
    logic [DW-1:0] ctrl_data_q,  ctrl_data_d;

    logic          rsp_valid_q,   rsp_valid_d;
    logic [AW-1:0] rsp_addr_q,    rsp_addr_d;
    logic [DW-1:0] rsp_data_q,    rsp_data_d;
    logic          rsp_error_q,   rsp_error_d;
    logic          rsp_timeout_q, rsp_timeout_d;

    logic full, empty, push, pop, retire, timed_out;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.cmd_valid & ~full;

    // FIFO storage has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write_q[wr_ptr_q] <= bus.cmd_write;
            fifo_addr_q[wr_ptr_q]  <= bus.cmd_addr;
            fifo_data_q[wr_ptr_q]  <= bus.cmd_data;
        end
    end

    // Occupancy follows push/pop; a simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Issue/retire decisions, ctrl bus next values and response capture.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        pop           = 1'b0;
        retire        = 1'b0;
        timed_out     = 1'b0;
        ctrl_ready_d  = ctrl_ready_q;
        ctrl_write_d  = ctrl_write_q;
        ctrl_addr_d   = ctrl_addr_q;
        ctrl_data_d   = ctrl_data_q;
        rsp_valid_d   = 1'b0;
        rsp_addr_d    = rsp_addr_q;
        rsp_data_d    = rsp_data_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (bus.dut_cwait) begin
                    if (wait_q == WW'(TMO - 1)) begin
                        retire    = 1'b1;
                        timed_out = 1'b1;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end else begin
                    retire = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (retire) begin
            // Writes only answer when they are aborted.
            if (timed_out || !ctrl_write_q) begin
                rsp_valid_d   = 1'b1;
                rsp_addr_d    = ctrl_addr_q;
                rsp_data_d    = timed_out ? '0 : bus.dut_data;
                rsp_error_d   = !timed_out &&
                                (!bus.dut_cready || (bus.dut_addr != ctrl_addr_q));
                rsp_timeout_d = timed_out;
            end
            // Chain straight into the next command so there is no bubble.
            if (!empty) begin
                pop = 1'b1;
            end else begin
                ctrl_ready_d = 1'b0;
                state_d      = S_IDLE;
            end
        end

        if (pop) begin
            ctrl_ready_d = 1'b1;
            ctrl_write_d = fifo_write_q[rd_ptr_q];
            ctrl_addr_d  = fifo_addr_q[rd_ptr_q];
            ctrl_data_d  = fifo_data_q[rd_ptr_q];
            wait_d       = '0;
        end
    end

    // State, pointers, ctrl bus and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= S_IDLE;
            wait_q        <= '0;
            ctrl_ready_q  <= 1'b0;
            ctrl_write_q  <= 1'b0;
            ctrl_addr_q   <= '0;
            ctrl_data_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_addr_q    <= '0;
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q       <= count_d;
            state_q       <= state_d;
            wait_q        <= wait_d;
            ctrl_ready_q  <= ctrl_ready_d;
            ctrl_write_q  <= ctrl_write_d;
            ctrl_addr_q   <= ctrl_addr_d;
            ctrl_data_q   <= ctrl_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_addr_q    <= rsp_addr_d;
            rsp_data_q    <= rsp_data_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready   = ~full;
    assign bus.busy        = ~empty | ctrl_ready_q;
    assign bus.ctrl_ready  = ctrl_ready_q;
    assign bus.ctrl_write  = ctrl_write_q;
    assign bus.ctrl_addr   = ctrl_addr_q;
    assign bus.ctrl_data   = ctrl_data_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_addr    = rsp_addr_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_error   = rsp_error_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_harness_ctrl_driver.sv
// Directed bench for harness_ctrl_driver (AW=16, DW=32, DEPTH=4, TMO=16).
module tb_harness_ctrl_driver;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    harness_ctrl_if #(.AW(16), .DW(32)) bus ();

    harness_ctrl_driver #(.AW(16), .DW(32), .DEPTH(4), .TMO(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic v, input logic w, input logic [15:0] a, input logic [31:0] d);
        bus.cmd_valid = v;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        set_cmd(1'b0, 1'b0, 16'h0, 32'h0);
        bus.dut_cwait  = 1'b0;
        bus.dut_cready = 1'b0;
        bus.dut_data   = 32'h0;
        bus.dut_addr   = 16'h0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset values
        chk("rst_ctrl_ready", bus.ctrl_ready, 0);
        chk("rst_ctrl_addr",  bus.ctrl_addr,  0);
        chk("rst_ctrl_data",  bus.ctrl_data,  0);
        chk("rst_rsp_valid",  bus.rsp_valid,  0);
        chk("rst_busy",       bus.busy,       0);
        chk("rst_cmd_ready",  bus.cmd_ready,  1);

        // Single write, zero wait
        set_cmd(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF);
        tick();
        set_cmd(1'b0, 1'b0, 16'h0, 32'h0);
        chk("wr_not_yet_issued", bus.ctrl_ready, 0);
        chk("wr_busy_queued",    bus.busy,       1);
        tick();
        chk("wr_ctrl_ready", bus.ctrl_ready, 1);
        chk("wr_ctrl_write", bus.ctrl_write, 1);
        chk("wr_ctrl_addr",  bus.ctrl_addr,  16'h0010);
        chk("wr_ctrl_data",  bus.ctrl_data,  32'hDEADBEEF);
        tick();
        chk("wr_ctrl_ready_drop", bus.ctrl_ready, 0);
        chk("wr_no_rsp",          bus.rsp_valid,  0);
        chk("wr_busy_idle",       bus.busy,       0);

        // Read with one wait cycle
        set_cmd(1'b1, 1'b0, 16'h0004, 32'h0);
        tick();
        set_cmd(1'b0, 1'b0, 16'h0, 32'h0);
        bus.dut_cwait = 1'b1;
        tick();
        chk("rd_issue_ready", bus.ctrl_ready, 1);
        chk("rd_issue_write", bus.ctrl_write, 0);
        chk("rd_issue_addr",  bus.ctrl_addr,  16'h0004);
        tick();
        chk("rd_hold_ready", bus.ctrl_ready, 1);
        chk("rd_hold_addr",  bus.ctrl_addr,  16'h0004);
        chk("rd_hold_norsp", bus.rsp_valid,  0);
        bus.dut_cwait  = 1'b0;
        bus.dut_cready = 1'b1;
        bus.dut_data   = 32'h12345678;
        bus.dut_addr   = 16'h0004;
        tick();
        bus.dut_cready = 1'b0;
        bus.dut_data   = 32'h0;
        bus.dut_addr   = 16'h0;
        chk("rd_rsp_valid",   bus.rsp_valid,   1);
        chk("rd_rsp_data",    bus.rsp_data,    32'h12345678);
        chk("rd_rsp_addr",    bus.rsp_addr,    16'h0004);
        chk("rd_rsp_error",   bus.rsp_error,   0);
        chk("rd_rsp_timeout", bus.rsp_timeout, 0);
        chk("rd_ctrl_drop",   bus.ctrl_ready,  0);
        tick();
        chk("rd_rsp_pulse_end", bus.rsp_valid, 0);

        // Back-to-back writes into a stalled DUT until the FIFO fills
        bus.dut_cwait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_cmd(1'b1, 1'b1, 16'h0100 + 16'(i), 32'hA0 + 32'(i));
            chk($sformatf("b2b_cmd_ready_%0d", i), bus.cmd_ready, 1);
            tick();
        end
        chk("b2b_full",        bus.cmd_ready,  0);
        chk("b2b_busy",        bus.busy,       1);
        chk("b2b_head_inflt",  bus.ctrl_addr,  16'h0100);
        set_cmd(1'b1, 1'b1, 16'h0BAD, 32'hBAD);
        tick();
        set_cmd(1'b0, 1'b0, 16'h0, 32'h0);
        chk("b2b_still_full",  bus.cmd_ready,  0);
        bus.dut_cwait = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("b2b_ready_%0d", i), bus.ctrl_ready, 1);
            chk($sformatf("b2b_addr_%0d", i),  bus.ctrl_addr,  16'h0100 + 16'(i));
            chk($sformatf("b2b_data_%0d", i),  bus.ctrl_data,  32'hA0 + 32'(i));
            tick();
            chk($sformatf("b2b_norsp_%0d", i), bus.rsp_valid, 0);
        end
        chk("b2b_drained_ready", bus.ctrl_ready, 0);
        chk("b2b_drained_busy",  bus.busy,       0);

        // Timeout on a read, with a write queued behind it
        bus.dut_cwait  = 1'b1;
        bus.dut_cready = 1'b1;
        bus.dut_data   = 32'hFFFFFFFF;
        bus.dut_addr   = 16'h0008;
        set_cmd(1'b1, 1'b0, 16'h0008, 32'h0);
        tick();
        set_cmd(1'b1, 1'b1, 16'h0020, 32'h55);
        tick();
        set_cmd(1'b0, 1'b0, 16'h0, 32'h0);
        chk("tmo_issue_addr", bus.ctrl_addr, 16'h0008);
        for (int i = 0; i < 15; i++) tick();
        chk("tmo_15_ready", bus.ctrl_ready, 1);
        chk("tmo_15_addr",  bus.ctrl_addr,  16'h0008);
        chk("tmo_15_norsp", bus.rsp_valid,  0);
        tick();
        chk("tmo_rsp_valid",   bus.rsp_valid,   1);
        chk("tmo_rsp_timeout", bus.rsp_timeout, 1);
        chk("tmo_rsp_data",    bus.rsp_data,    0);
        chk("tmo_rsp_error",   bus.rsp_error,   0);
        chk("tmo_rsp_addr",    bus.rsp_addr,    16'h0008);
        chk("tmo_next_ready",  bus.ctrl_ready,  1);
        chk("tmo_next_addr",   bus.ctrl_addr,   16'h0020);
        chk("tmo_next_write",  bus.ctrl_write,  1);
        bus.dut_cwait  = 1'b0;
        bus.dut_cready = 1'b0;
        bus.dut_data   = 32'h0;
        bus.dut_addr   = 16'h0;
        tick();
        chk("tmo_wr_norsp",  bus.rsp_valid,  0);
        chk("tmo_wr_done",   bus.ctrl_ready, 0);

        // Read retired without dut_cready
        set_cmd(1'b1, 1'b0, 16'h0008, 32'h0);
        tick();
        set_cmd(1'b0, 1'b0, 16'h0, 32'h0);
        tick();
        bus.dut_cready = 1'b0;
        bus.dut_data   = 32'hCAFE0001;
        bus.dut_addr   = 16'h0008;
        tick();
        chk("err_nordy_valid", bus.rsp_valid, 1);
        chk("err_nordy_error", bus.rsp_error, 1);
        chk("err_nordy_data",  bus.rsp_data,  32'hCAFE0001);

        // Read retired with a mismatched echoed address
        set_cmd(1'b1, 1'b0, 16'h0008, 32'h0);
        tick();
        set_cmd(1'b0, 1'b0, 16'h0, 32'h0);
        tick();
        bus.dut_cready = 1'b1;
        bus.dut_data   = 32'hCAFE0002;
        bus.dut_addr   = 16'h0009;
        tick();
        chk("err_addr_valid", bus.rsp_valid, 1);
        chk("err_addr_error", bus.rsp_error, 1);
        chk("err_addr_addr",  bus.rsp_addr,  16'h0008);
        bus.dut_cready = 1'b0;
        bus.dut_data   = 32'h0;
        bus.dut_addr   = 16'h0;
        tick();

        // Reset during a stall with three commands queued
        bus.dut_cwait = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_cmd(1'b1, 1'b0, 16'h0200 + 16'(i), 32'h0);
            tick();
        end
        set_cmd(1'b0, 1'b0, 16'h0, 32'h0);
        chk("mid_busy",  bus.busy,       1);
        chk("mid_ready", bus.ctrl_ready, 1);
        chk("mid_addr",  bus.ctrl_addr,  16'h0200);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_ctrl_ready", bus.ctrl_ready, 0);
        chk("arst_ctrl_addr",  bus.ctrl_addr,  0);
        chk("arst_rsp_data",   bus.rsp_data,   0);
        chk("arst_rsp_addr",   bus.rsp_addr,   0);
        chk("arst_busy",       bus.busy,       0);
        chk("arst_cmd_ready",  bus.cmd_ready,  1);
        tick();
        reset         = 1'b0;
        bus.dut_cwait = 1'b0;
        tick();
        tick();
        chk("post_rst_norsp",  bus.rsp_valid,  0);
        chk("post_rst_idle",   bus.ctrl_ready, 0);
        chk("post_rst_busy",   bus.busy,       0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
